// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I opcode constants, issue-stage op encodings,
// immediate-format enum and the immediate extraction helper.
package riscv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [5:0] {
    OP_ILLEGAL = 6'd0,
    OP_LUI     = 6'd1,
    OP_AUIPC   = 6'd2,
    OP_JAL     = 6'd3,
    OP_JALR    = 6'd4,
    OP_BEQ     = 6'd5,
    OP_BNE     = 6'd6,
    OP_BLT     = 6'd7,
    OP_BGE     = 6'd8,
    OP_BLTU    = 6'd9,
    OP_BGEU    = 6'd10,
    OP_LB      = 6'd11,
    OP_LH      = 6'd12,
    OP_LW      = 6'd13,
    OP_LBU     = 6'd14,
    OP_LHU     = 6'd15,
    OP_SB      = 6'd16,
    OP_SH      = 6'd17,
    OP_SW      = 6'd18,
    OP_ADDI    = 6'd19,
    OP_SLTI    = 6'd20,
    OP_SLTIU   = 6'd21,
    OP_XORI    = 6'd22,
    OP_ORI     = 6'd23,
    OP_ANDI    = 6'd24,
    OP_SLLI    = 6'd25,
    OP_SRLI    = 6'd26,
    OP_SRAI    = 6'd27,
    OP_ADD     = 6'd28,
    OP_SUB     = 6'd29,
    OP_SLL     = 6'd30,
    OP_SLT     = 6'd31,
    OP_SLTU    = 6'd32,
    OP_XOR     = 6'd33,
    OP_SRL     = 6'd34,
    OP_SRA     = 6'd35,
    OP_OR      = 6'd36,
    OP_AND     = 6'd37
  } op_e;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5
  } imm_fmt_e;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } issue_state_e;

  // Sign-extended immediate for the given encoding format; R-type and
  // illegal instructions carry no immediate and yield zero.
  function automatic logic [31:0] imm_gen(input logic [31:0] inst, input imm_fmt_e fmt);
    logic [31:0] imm;
    imm = '0;
    case (fmt)
      FMT_I: imm = {{20{inst[31]}}, inst[31:20]};
      FMT_S: imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      FMT_B: imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      FMT_U: imm = {inst[31:12], 12'h000};
      FMT_J: imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/inst_decoder.sv
// inst_decoder: purely combinational RV32I decode for the issue stage.
// Produces the op code, register fields (zeroed where the format has no
// such field), immediate, destination routing and the ROB-resolve flag.
module inst_decoder (
  input  logic [31:0] inst,
  output logic [5:0]  op,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [31:0] imm,
  output logic        jump,
  output logic        to_rs,
  output logic        to_lsb
);
  import riscv_pkg::*;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  op_e        op_dec;
  imm_fmt_e   fmt;
  logic       use_rd;
  logic       use_rs1;
  logic       use_rs2;
  logic       is_mem;
  logic       is_jump;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];

  // Opcode/funct decode; any unrecognised combination collapses to OP_ILLEGAL
  // with every side-band flag cleared so it goes to the ROB alone.
  always_comb begin
    op_dec  = OP_ILLEGAL;
    fmt     = FMT_NONE;
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    is_mem  = 1'b0;
    is_jump = 1'b0;
    case (opcode)
      OPC_LUI: begin
        op_dec = OP_LUI;
        fmt    = FMT_U;
        use_rd = 1'b1;
      end
      OPC_AUIPC: begin
        op_dec = OP_AUIPC;
        fmt    = FMT_U;
        use_rd = 1'b1;
      end
      OPC_JAL: begin
        op_dec = OP_JAL;
        fmt    = FMT_J;
        use_rd = 1'b1;
      end
      OPC_JALR: begin
        if (funct3 == 3'b000) op_dec = OP_JALR;
        fmt     = FMT_I;
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        is_jump = 1'b1;
      end
      OPC_BRANCH: begin
        case (funct3)
          3'b000:  op_dec = OP_BEQ;
          3'b001:  op_dec = OP_BNE;
          3'b100:  op_dec = OP_BLT;
          3'b101:  op_dec = OP_BGE;
          3'b110:  op_dec = OP_BLTU;
          3'b111:  op_dec = OP_BGEU;
          default: op_dec = OP_ILLEGAL;
        endcase
        fmt     = FMT_B;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        is_jump = 1'b1;
      end
      OPC_LOAD: begin
        case (funct3)
          3'b000:  op_dec = OP_LB;
          3'b001:  op_dec = OP_LH;
          3'b010:  op_dec = OP_LW;
          3'b100:  op_dec = OP_LBU;
          3'b101:  op_dec = OP_LHU;
          default: op_dec = OP_ILLEGAL;
        endcase
        fmt     = FMT_I;
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        is_mem  = 1'b1;
      end
      OPC_STORE: begin
        case (funct3)
          3'b000:  op_dec = OP_SB;
          3'b001:  op_dec = OP_SH;
          3'b010:  op_dec = OP_SW;
          default: op_dec = OP_ILLEGAL;
        endcase
        fmt     = FMT_S;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        is_mem  = 1'b1;
      end
      OPC_OP_IMM: begin
        case (funct3)
          3'b000: op_dec = OP_ADDI;
          3'b010: op_dec = OP_SLTI;
          3'b011: op_dec = OP_SLTIU;
          3'b100: op_dec = OP_XORI;
          3'b110: op_dec = OP_ORI;
          3'b111: op_dec = OP_ANDI;
          3'b001: op_dec = (funct7 == F7_BASE) ? OP_SLLI : OP_ILLEGAL;
          3'b101: begin
            if (funct7 == F7_BASE)     op_dec = OP_SRLI;
            else if (funct7 == F7_ALT) op_dec = OP_SRAI;
            else                       op_dec = OP_ILLEGAL;
          end
          default: op_dec = OP_ILLEGAL;
        endcase
        fmt     = FMT_I;
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
      end
      OPC_OP: begin
        case ({funct7, funct3})
          {F7_BASE, 3'b000}: op_dec = OP_ADD;
          {F7_ALT,  3'b000}: op_dec = OP_SUB;
          {F7_BASE, 3'b001}: op_dec = OP_SLL;
          {F7_BASE, 3'b010}: op_dec = OP_SLT;
          {F7_BASE, 3'b011}: op_dec = OP_SLTU;
          {F7_BASE, 3'b100}: op_dec = OP_XOR;
          {F7_BASE, 3'b101}: op_dec = OP_SRL;
          {F7_ALT,  3'b101}: op_dec = OP_SRA;
          {F7_BASE, 3'b110}: op_dec = OP_OR;
          {F7_BASE, 3'b111}: op_dec = OP_AND;
          default:           op_dec = OP_ILLEGAL;
        endcase
        fmt     = FMT_NONE;
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      default: op_dec = OP_ILLEGAL;
    endcase
    if (op_dec == OP_ILLEGAL) begin
      fmt     = FMT_NONE;
      use_rd  = 1'b0;
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      is_mem  = 1'b0;
      is_jump = 1'b0;
    end
  end

  assign op     = op_dec;
  assign rd     = use_rd  ? inst[11:7]  : 5'd0;
  assign rs1    = use_rs1 ? inst[19:15] : 5'd0;
  assign rs2    = use_rs2 ? inst[24:20] : 5'd0;
  assign imm    = imm_gen(inst, fmt);
  assign jump   = is_jump;
  assign to_lsb = is_mem;
  assign to_rs  = (op_dec != OP_ILLEGAL) && !is_mem;

endmodule

// File: rtl/issue_unit.sv
// issue_unit: single-entry decode/issue stage between the instruction queue
// and the ROB / reservation station / load-store buffer.
//   state | meaning
//   IDLE  | stage empty, ready to accept
//   HOLD  | decoded instruction latched, waiting for a free target
// Optional build macro ISSUE_STALL_CNT_EN adds a 32-bit stall_cnt output
// counting HOLD cycles in which the latched instruction could not issue.
module issue_unit #(
  parameter int ROB_IDX_W = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 iq_valid,
  input  logic [31:0]          iq_inst,
  input  logic [31:0]          iq_pc,
  input  logic                 iq_pred_jump,
  output logic                 iq_ready,
  input  logic                 rob_full,
  input  logic                 rs_full,
  input  logic                 lsb_full,
  input  logic [ROB_IDX_W-1:0] next_index,
  input  logic                 flush,
  output logic                 issue_valid,
  output logic [4:0]           issue_rd,
  output logic [4:0]           issue_rs1,
  output logic [4:0]           issue_rs2,
  output logic                 issue_jump,
  output logic                 issue_pred,
  output logic [5:0]           issue_op,
  output logic [31:0]          issue_imm,
  output logic [31:0]          issue_pc,
  output logic [ROB_IDX_W-1:0] issue_rob_idx,
  output logic                 issue_to_rs,
  output logic                 issue_to_lsb
`ifdef ISSUE_STALL_CNT_EN
  ,
  output logic [31:0]          stall_cnt
`endif
);
  import riscv_pkg::*;

  issue_state_e state;

  logic [5:0]  dec_op;
  logic [4:0]  dec_rd;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic [31:0] dec_imm;
  logic        dec_jump;
  logic        dec_to_rs;
  logic        dec_to_lsb;

  logic target_free;
  logic accept;
  logic drop;

  inst_decoder u_dec (
    .inst   (iq_inst),
    .op     (dec_op),
    .rd     (dec_rd),
    .rs1    (dec_rs1),
    .rs2    (dec_rs2),
    .imm    (dec_imm),
    .jump   (dec_jump),
    .to_rs  (dec_to_rs),
    .to_lsb (dec_to_lsb)
  );

  // Handshake: an instruction leaves when its own target has room; a new one
  // can enter in the same cycle, giving one instruction per cycle. iq_ready is
  // also gated by reset so every output reads zero while rst is low.
  assign target_free = !rob_full && !(issue_to_rs && rs_full) && !(issue_to_lsb && lsb_full);
  assign issue_valid = (state == HOLD) && target_free && rdy && !flush;
  assign iq_ready    = rst && rdy && !flush && ((state == IDLE) || issue_valid);
  assign accept      = iq_valid && iq_ready;

  // ROB slot is not latched: it must track the ROB tail in the issue cycle.
  assign issue_rob_idx = issue_valid ? next_index : '0;

  // Stage is emptied by a flush (even while frozen) or by issuing with nothing
  // new arriving; fields are cleared so an empty stage shows all zeros.
  assign drop = flush || (rdy && issue_valid && !accept);

  // Stage FSM and latched decode fields.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      issue_rd     <= '0;
      issue_rs1    <= '0;
      issue_rs2    <= '0;
      issue_jump   <= 1'b0;
      issue_pred   <= 1'b0;
      issue_op     <= '0;
      issue_imm    <= '0;
      issue_pc     <= '0;
      issue_to_rs  <= 1'b0;
      issue_to_lsb <= 1'b0;
    end else if (drop) begin
      state        <= IDLE;
      issue_rd     <= '0;
      issue_rs1    <= '0;
      issue_rs2    <= '0;
      issue_jump   <= 1'b0;
      issue_pred   <= 1'b0;
      issue_op     <= '0;
      issue_imm    <= '0;
      issue_pc     <= '0;
      issue_to_rs  <= 1'b0;
      issue_to_lsb <= 1'b0;
    end else if (accept) begin
      state        <= HOLD;
      issue_rd     <= dec_rd;
      issue_rs1    <= dec_rs1;
      issue_rs2    <= dec_rs2;
      issue_jump   <= dec_jump;
      issue_pred   <= iq_pred_jump;
      issue_op     <= dec_op;
      issue_imm    <= dec_imm;
      issue_pc     <= iq_pc;
      issue_to_rs  <= dec_to_rs;
      issue_to_lsb <= dec_to_lsb;
    end
  end

`ifdef ISSUE_STALL_CNT_EN
  // Count cycles where a held instruction is blocked only by a full target.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if ((state == HOLD) && rdy && !flush && !issue_valid) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_issue_unit.sv
// tb_issue_unit: table-driven decode/issue checks through a scoreboard,
// plus hand sequences for stalls, back-to-back flow, flush, rdy and reset.
module tb_issue_unit;

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        jump;
    logic        pred;
    logic        to_rs;
    logic        to_lsb;
    logic [31:0] pc;
    logic [2:0]  dc;   // [0] rs1, [1] rs2, [2] imm not checked
  } exp_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pred;
    exp_t        e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic        iq_valid = 1'b0;
  logic [31:0] iq_inst = '0;
  logic [31:0] iq_pc = '0;
  logic        iq_pred_jump = 1'b0;
  logic        iq_ready;
  logic        rob_full = 1'b0;
  logic        rs_full = 1'b0;
  logic        lsb_full = 1'b0;
  logic [5:0]  next_index = '0;
  logic        flush = 1'b0;
  logic        issue_valid;
  logic [4:0]  issue_rd, issue_rs1, issue_rs2;
  logic        issue_jump, issue_pred;
  logic [5:0]  issue_op;
  logic [31:0] issue_imm, issue_pc;
  logic [5:0]  issue_rob_idx;
  logic        issue_to_rs, issue_to_lsb;
`ifdef ISSUE_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int   n_tests = 0;
  int   n_fail = 0;
  exp_t sb[$];
  exp_t cur_exp;
  vec_t tbl[13];

  issue_unit #(.ROB_IDX_W(6)) dut (
    .clk           (clk),
    .rst           (rst),
    .rdy           (rdy),
    .iq_valid      (iq_valid),
    .iq_inst       (iq_inst),
    .iq_pc         (iq_pc),
    .iq_pred_jump  (iq_pred_jump),
    .iq_ready      (iq_ready),
    .rob_full      (rob_full),
    .rs_full       (rs_full),
    .lsb_full      (lsb_full),
    .next_index    (next_index),
    .flush         (flush),
    .issue_valid   (issue_valid),
    .issue_rd      (issue_rd),
    .issue_rs1     (issue_rs1),
    .issue_rs2     (issue_rs2),
    .issue_jump    (issue_jump),
    .issue_pred    (issue_pred),
    .issue_op      (issue_op),
    .issue_imm     (issue_imm),
    .issue_pc      (issue_pc),
    .issue_rob_idx (issue_rob_idx),
    .issue_to_rs   (issue_to_rs),
    .issue_to_lsb  (issue_to_lsb)
`ifdef ISSUE_STALL_CNT_EN
    ,
    .stall_cnt     (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic vec_t mk(input logic [31:0] inst, input logic [31:0] pc, input logic pred,
                              input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [31:0] imm, input logic jump,
                              input logic to_rs, input logic to_lsb, input logic [2:0] dc);
    vec_t v;
    v.inst = inst; v.pc = pc; v.pred = pred;
    v.e.op = op; v.e.rd = rd; v.e.rs1 = rs1; v.e.rs2 = rs2; v.e.imm = imm;
    v.e.jump = jump; v.e.pred = pred; v.e.to_rs = to_rs; v.e.to_lsb = to_lsb;
    v.e.pc = pc; v.e.dc = dc;
    return v;
  endfunction

  // Scoreboard: pop and compare on every issue, push on every accept,
  // discard the in-flight entry on flush.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (flush) begin
        sb.delete();
      end else if (issue_valid) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_issue: got issue_valid=1 expected no pending instruction at %0t", $time);
        end else begin
          e = sb.pop_front();
          chk("issue_op", {26'd0, issue_op}, {26'd0, e.op});
          chk("issue_rd", {27'd0, issue_rd}, {27'd0, e.rd});
          if (!e.dc[0]) chk("issue_rs1", {27'd0, issue_rs1}, {27'd0, e.rs1});
          if (!e.dc[1]) chk("issue_rs2", {27'd0, issue_rs2}, {27'd0, e.rs2});
          if (!e.dc[2]) chk("issue_imm", issue_imm, e.imm);
          chk("issue_jump", {31'd0, issue_jump}, {31'd0, e.jump});
          chk("issue_pred", {31'd0, issue_pred}, {31'd0, e.pred});
          chk("issue_to_rs", {31'd0, issue_to_rs}, {31'd0, e.to_rs});
          chk("issue_to_lsb", {31'd0, issue_to_lsb}, {31'd0, e.to_lsb});
          chk("issue_pc", issue_pc, e.pc);
          chk("issue_rob_idx", {26'd0, issue_rob_idx}, {26'd0, next_index});
        end
      end
      if (iq_valid && iq_ready) sb.push_back(cur_exp);
    end
  end

  task automatic drive(input vec_t v);
    iq_inst      = v.inst;
    iq_pc        = v.pc;
    iq_pred_jump = v.pred;
    cur_exp      = v.e;
    iq_valid     = 1'b1;
  endtask

  // Present one instruction, wait (bounded) for acceptance, then withdraw.
  task automatic send(input vec_t v);
    int n;
    drive(v);
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (iq_ready) break;
    end
    if (n == 20) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    iq_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    for (n = 0; n < 20; n++) begin
      if (sb.size() == 0) break;
      @(posedge clk); #1;
    end
    chk("drain", sb.size(), 32'd0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_issue_valid"}, {31'd0, issue_valid}, 32'd0);
    chk({tag, "_iq_ready"}, {31'd0, iq_ready}, 32'd0);
    chk({tag, "_issue_rd"}, {27'd0, issue_rd}, 32'd0);
    chk({tag, "_issue_op"}, {26'd0, issue_op}, 32'd0);
    chk({tag, "_issue_imm"}, issue_imm, 32'd0);
    chk({tag, "_issue_pc"}, issue_pc, 32'd0);
    chk({tag, "_issue_to_lsb"}, {31'd0, issue_to_lsb}, 32'd0);
    chk({tag, "_issue_to_rs"}, {31'd0, issue_to_rs}, 32'd0);
    chk({tag, "_issue_rob_idx"}, {26'd0, issue_rob_idx}, 32'd0);
`ifdef ISSUE_STALL_CNT_EN
    chk({tag, "_stall_cnt"}, stall_cnt, 32'd0);
`endif
  endtask

  initial begin
    vec_t va, vb, vsw, vlw;
    logic [31:0] stall_base;
    stall_base = '0;

    tbl[0]  = mk(enc_i(12'hFFD, 5'd1, 3'b000, 5'd5, 7'b0010011), 32'h100, 1'b0,
                 6'd19, 5'd5, 5'd1, 5'd0, 32'hFFFF_FFFD, 1'b0, 1'b1, 1'b0, 3'b010);
    tbl[1]  = mk(enc_s(12'd8, 5'd7, 5'd2, 3'b010), 32'h104, 1'b0,
                 6'd18, 5'd0, 5'd2, 5'd7, 32'h0000_0008, 1'b0, 1'b0, 1'b1, 3'b000);
    tbl[2]  = mk(enc_b(13'h1FF0, 5'd4, 5'd3, 3'b000), 32'h108, 1'b1,
                 6'd5, 5'd0, 5'd3, 5'd4, 32'hFFFF_FFF0, 1'b1, 1'b1, 1'b0, 3'b000);
    tbl[3]  = mk(32'h1234_5537, 32'h10C, 1'b0,
                 6'd1, 5'd10, 5'd0, 5'd0, 32'h1234_5000, 1'b0, 1'b1, 1'b0, 3'b011);
    tbl[4]  = mk(enc_j(21'h000800, 5'd1), 32'h110, 1'b1,
                 6'd3, 5'd1, 5'd0, 5'd0, 32'h0000_0800, 1'b0, 1'b1, 1'b0, 3'b011);
    tbl[5]  = mk(enc_i(12'd4, 5'd6, 3'b000, 5'd1, 7'b1100111), 32'h114, 1'b0,
                 6'd4, 5'd1, 5'd6, 5'd0, 32'h0000_0004, 1'b1, 1'b1, 1'b0, 3'b010);
    tbl[6]  = mk(enc_i(12'hFFC, 5'd9, 3'b010, 5'd8, 7'b0000011), 32'h118, 1'b0,
                 6'd13, 5'd8, 5'd9, 5'd0, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b1, 3'b010);
    tbl[7]  = mk(enc_r(7'b0100000, 5'd13, 5'd12, 3'b000, 5'd11), 32'h11C, 1'b0,
                 6'd29, 5'd11, 5'd12, 5'd13, 32'h0, 1'b0, 1'b1, 1'b0, 3'b100);
    tbl[8]  = mk(enc_i(12'h403, 5'd15, 3'b101, 5'd14, 7'b0010011), 32'h120, 1'b0,
                 6'd27, 5'd14, 5'd15, 5'd0, 32'h0000_0403, 1'b0, 1'b1, 1'b0, 3'b010);
    tbl[9]  = mk(32'hFFFF_FFFF, 32'h124, 1'b0,
                 6'd0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 3'b111);
    tbl[10] = mk(enc_b(13'd8, 5'd2, 5'd1, 3'b010), 32'h128, 1'b1,
                 6'd0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 3'b111);
    tbl[11] = mk(enc_b(13'h0FFE, 5'd6, 5'd5, 3'b101), 32'h12C, 1'b0,
                 6'd8, 5'd0, 5'd5, 5'd6, 32'h0000_0FFE, 1'b1, 1'b1, 1'b0, 3'b000);
    tbl[12] = mk({20'hFFFFF, 5'd3, 7'b0010111}, 32'h130, 1'b0,
                 6'd2, 5'd3, 5'd0, 5'd0, 32'hFFFF_F000, 1'b0, 1'b1, 1'b0, 3'b011);

    // Reset state: everything zero, iq_ready low even with rdy high.
    #12;
    chk_zero_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("idle_iq_ready", {31'd0, iq_ready}, 32'd1);
    chk("idle_issue_valid", {31'd0, issue_valid}, 32'd0);
    @(posedge clk); #1;

    // Table: each instruction alone, no stalls.
    for (int i = 0; i < 13; i++) begin
      next_index = 6'($urandom_range(0, 63));
      send(tbl[i]);
      drain();
    end

    // Store stalled by a full LSB for three cycles, then issues while the
    // next instruction is accepted in the same cycle.
`ifdef ISSUE_STALL_CNT_EN
    stall_base = stall_cnt;
`endif
    vsw = tbl[1];
    va  = tbl[0];
    lsb_full = 1'b1;
    next_index = 6'd21;
    drive(vsw);
    @(negedge clk);
    chk("sw_accept", {31'd0, iq_ready}, 32'd1);
    @(posedge clk); #1;
    drive(va);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("sw_stall_valid", {31'd0, issue_valid}, 32'd0);
      chk("sw_stall_ready", {31'd0, iq_ready}, 32'd0);
      chk("sw_stall_imm", issue_imm, 32'd8);
      chk("sw_stall_rs2", {27'd0, issue_rs2}, 32'd7);
      chk("sw_stall_lsb", {31'd0, issue_to_lsb}, 32'd1);
      @(posedge clk); #1;
    end
    lsb_full = 1'b0;
    @(negedge clk);
    chk("sw_issue_valid", {31'd0, issue_valid}, 32'd1);
    chk("sw_next_accept", {31'd0, iq_ready}, 32'd1);
    @(posedge clk); #1;
    iq_valid = 1'b0;
    drain();
`ifdef ISSUE_STALL_CNT_EN
    chk("stall_cnt_sw", stall_cnt, stall_base + 32'd3);
`endif

    // Back-to-back stream of four: four consecutive issue cycles.
    for (int k = 0; k < 4; k++) begin
      next_index = 6'(10 + k);
      drive(tbl[k + 5]);
      @(negedge clk);
      chk("b2b_ready", {31'd0, iq_ready}, 32'd1);
      if (k > 0) chk("b2b_valid", {31'd0, issue_valid}, 32'd1);
      @(posedge clk); #1;
    end
    iq_valid = 1'b0;
    next_index = 6'd14;
    @(negedge clk);
    chk("b2b_valid_last", {31'd0, issue_valid}, 32'd1);
    @(posedge clk); #1;
    drain();

    // Flush while holding with another instruction offered.
    rob_full = 1'b1;
    drive(tbl[3]);
    @(negedge clk);
    @(posedge clk); #1;
    drive(tbl[7]);
    @(negedge clk);
    chk("flush_pre_valid", {31'd0, issue_valid}, 32'd0);
    chk("flush_pre_ready", {31'd0, iq_ready}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b1;
    rob_full = 1'b0;
    @(negedge clk);
    chk("flush_valid", {31'd0, issue_valid}, 32'd0);
    chk("flush_ready", {31'd0, iq_ready}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    iq_valid = 1'b0;
    @(negedge clk);
    chk("flush_idle_ready", {31'd0, iq_ready}, 32'd1);
    chk("flush_idle_valid", {31'd0, issue_valid}, 32'd0);
    @(negedge clk);
    chk("flush_dropped", {31'd0, issue_valid}, 32'd0);
    @(posedge clk); #1;

    // rdy low freezes a held instruction.
    vb = tbl[8];
    drive(vb);
    @(negedge clk);
    @(posedge clk); #1;
    iq_valid = 1'b0;
    rdy = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("rdy_low_valid", {31'd0, issue_valid}, 32'd0);
      chk("rdy_low_ready", {31'd0, iq_ready}, 32'd0);
      chk("rdy_low_rd", {27'd0, issue_rd}, 32'd14);
      @(posedge clk); #1;
    end
    rdy = 1'b1;
    drain();

    // Reset in the middle of a stall.
    vlw = tbl[6];
    rob_full = 1'b1;
`ifdef ISSUE_STALL_CNT_EN
    stall_base = stall_cnt;
`endif
    drive(vlw);
    @(negedge clk);
    @(posedge clk); #1;
    iq_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
`ifdef ISSUE_STALL_CNT_EN
    chk("stall_cnt_pre_rst", stall_cnt, stall_base + 32'd2);
`endif
    chk("pre_rst_rd", {27'd0, issue_rd}, 32'd8);
    #2;
    rst = 1'b0;
    #1;
    sb.delete();
    chk_zero_outputs("midrst");
    @(posedge clk); #1;
    rst = 1'b1;
    rob_full = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, iq_ready}, 32'd1);
    chk("post_rst_valid", {31'd0, issue_valid}, 32'd0);
    @(posedge clk); #1;

    chk("sb_empty_end", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/issue_unit.md
ISSUE_UNIT -- requirements
Module: issue_unit

Interface
REQ-001 Parameter: ROB_IDX_W, 6, width of ROB entry index.
REQ-002 clk  input  1  system clock, rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 rdy  input  1  global enable; low freezes all state.
REQ-005 iq_valid  input  1  instruction queue holds an instruction.
REQ-006 iq_inst / iq_pc  input  32 / 32  instruction word and its PC.
REQ-007 iq_pred_jump  input  1  predictor says taken.
REQ-008 iq_ready  output  1  unit accepts the instruction this cycle.
REQ-009 rob_full / rs_full / lsb_full  input  1 each  downstream full flags.
REQ-010 next_index  input  ROB_IDX_W  ROB slot the next issue will occupy.
REQ-011 flush  input  1  mispredict flush from ROB.
REQ-012 issue_valid  output  1  issue strobe to ROB, RS or LSB.
REQ-013 issue_rd / issue_rs1 / issue_rs2  output  5 each  register fields.
REQ-014 issue_jump  output  1  ROB must resolve this instruction (branch or JALR).
REQ-015 issue_pred  output  1  predicted-taken bit carried to ROB.
REQ-016 issue_op  output  6  decoded operation code.
REQ-017 issue_imm / issue_pc  output  32 / 32  sign-extended immediate and PC.
REQ-018 issue_rob_idx  output  ROB_IDX_W  next_index sampled at the issue cycle.
REQ-019 issue_to_rs / issue_to_lsb  output  1 each  destination select.

Function
REQ-020 The FSM SHALL have two states: IDLE (stage empty) and HOLD (decoded instruction latched).
REQ-021 Accept = iq_valid && iq_ready; accepted instruction SHALL be decoded and latched at that edge; state becomes HOLD.
REQ-022 Target free = !rob_full && !(issue_to_rs && rs_full) && !(issue_to_lsb && lsb_full).
REQ-023 issue_valid SHALL equal state==HOLD && target free && rdy && !flush.
REQ-024 iq_ready SHALL equal rdy && !flush && (state==IDLE || issue_valid), giving throughput of one instruction per cycle.
REQ-025 Latency: instruction accepted at edge N SHALL appear on issue_valid no earlier than the cycle after edge N.
REQ-026 HOLD with issue_valid and no accept SHALL go to IDLE; with accept SHALL stay HOLD with new contents.
REQ-027 HOLD without issue_valid SHALL keep all latched fields stable.
REQ-028 issue_rob_idx SHALL be next_index combinationally during the issue_valid cycle.
REQ-029 Loads and stores SHALL route to LSB; all other legal opcodes SHALL route to RS.
REQ-030 Unknown opcodes SHALL decode to OP_ILLEGAL, route to neither RS nor LSB, and issue to the ROB only.
REQ-031 issue_rd SHALL be 0 for branches, stores and illegal opcodes; issue_jump SHALL be 1 only for B-type and JALR.
REQ-032 issue_imm SHALL be sign-extended per I/S/B/U/J format; U-type SHALL be imm[31:12]<<12.
REQ-033 Flush SHALL force issue_valid=0 and iq_ready=0 that cycle; next state SHALL be IDLE and the latched instruction SHALL be dropped.
REQ-034 Flush SHALL have priority over rdy and over a pending accept.
REQ-035 rdy=0 SHALL hold state and fields, with issue_valid=0 and iq_ready=0.

Reset
REQ-036 rst low SHALL immediately force state IDLE and all outputs and latched fields to 0, independent of clk and rdy.

Configuration
REQ-037 With ISSUE_STALL_CNT_EN defined, output stall_cnt (32 bits) SHALL count cycles with state==HOLD && rdy && !flush && !issue_valid.
REQ-038 stall_cnt SHALL reset to 0 and wrap at 2^32.
REQ-039 Without ISSUE_STALL_CNT_EN, the stall_cnt port and counter SHALL be absent and behaviour SHALL be otherwise identical.

Structure
REQ-040 Shared package riscv_pkg SHALL hold opcode constants, the 6-bit op encodings including OP_ILLEGAL, and the immediate-format enum.
REQ-041 Decode SHALL live in a combinational sub-module inst_decoder, instantiated once.

Verification
REQ-042 Test 1: addi x5,x1,-3 at PC 0x100, all flags clear -> next cycle issue_valid=1, rd=5, imm=0xFFFFFFFD, issue_to_rs=1, rob_idx=next_index.
REQ-043 Test 2: sw with lsb_full=1 for 3 cycles -> issue_valid=0 for 3 cycles, iq_ready=0, fields stable; issues on the 4th cycle with issue_to_lsb=1 and rd=0.
REQ-044 Test 3: beq with iq_pred_jump=1 -> issue_jump=1, issue_pred=1, rd=0, correct B immediate.
REQ-045 Test 4: back-to-back valid stream of 4 instructions, no stalls -> 4 consecutive issue_valid cycles.
REQ-046 Test 5: flush while in HOLD with iq_valid=1 -> no issue, no accept; IDLE next cycle.
REQ-047 Test 6: rst asserted mid-stall -> outputs 0 immediately; stall_cnt=0 when ISSUE_STALL_CNT_EN is defined.
